// File: rtl/div_arbiter_pkg.sv
// Shared types and default widths for the round-robin divider arbiter.
// The state enum and index-width helper are used by the top and the testbench.
package div_arbiter_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DIVIDEND_WIDTH = 64;
  localparam int DEF_DIVISOR_WIDTH  = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester and divider-side signals of the divider arbiter.
// The slave modport is the arbiter view; master is the environment driving it.
interface div_arbiter_if
  import div_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) ();

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend;
  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor;
  logic [NUM_REQ-1:0]                resp_valid;
  logic [DIVIDEND_WIDTH-1:0]         resp_quotient;
  logic [DIVISOR_WIDTH-1:0]          resp_remainder;
  logic                              resp_overflow;
  logic                              div_valid_in;
  logic [DIVIDEND_WIDTH-1:0]         div_dividend;
  logic [DIVISOR_WIDTH-1:0]          div_divisor;
  logic [DIVIDEND_WIDTH-1:0]         div_quotient;
  logic [DIVISOR_WIDTH-1:0]          div_remainder;
  logic                              div_overflow;
  logic                              div_valid_out;
  logic                              timeout_err;

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    input  div_quotient, div_remainder, div_overflow, div_valid_out,
    output req_ready, resp_valid, resp_quotient, resp_remainder, resp_overflow,
    output div_valid_in, div_dividend, div_divisor, timeout_err
  );

  modport master (
    output req_valid, req_dividend, req_divisor,
    output div_quotient, div_remainder, div_overflow, div_valid_out,
    input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_overflow,
    input  div_valid_in, div_dividend, div_divisor, timeout_err
  );

endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward
// from the requester after last_grant, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int               sum_s;
  logic [IDX_W-1:0] cand_s;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {IDX_W{1'b0}};
    sum_s       = 0;
    cand_s      = {IDX_W{1'b0}};
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum_s       = (int'(last_grant) + off) % NUM_REQ;
      cand_s      = IDX_W'(sum_s);
      grant_valid = grant_valid | req[cand_s];
      grant_idx   = req[cand_s] ? cand_s : grant_idx;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider among NUM_REQ requesters with round-robin
// arbitration, a single outstanding operation, divide-by-zero bypass and a WAIT timeout.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic          clk,
  input logic          reset,
  div_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                    state_r, state_s;
  logic [IDX_W-1:0]          last_grant_r, grant_r, arb_idx_s;
  logic                      arb_valid_s, accept_s, timeout_hit_s;
  logic [DIVIDEND_WIDTH-1:0] dividend_r, quot_r;
  logic [DIVISOR_WIDTH-1:0]  divisor_r, rem_r;
  logic                      ovf_r, timeout_err_r, div_valid_in_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [NUM_REQ-1:0]        resp_valid_r, req_ready_s;
  logic [DIVIDEND_WIDTH-1:0] req_dividend_s [NUM_REQ];
  logic [DIVISOR_WIDTH-1:0]  req_divisor_s  [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_dividend_s[g] = bus.req_dividend[g*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
    assign req_divisor_s[g]  = bus.req_divisor[g*DIVISOR_WIDTH +: DIVISOR_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req         (bus.req_valid),
    .last_grant  (last_grant_r),
    .grant_valid (arb_valid_s),
    .grant_idx   (arb_idx_s)
  );

  // Next-state decode; a grant is never offered while reset is held.
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s && !reset) begin
          accept_s = 1'b1;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (divisor_r == {DIVISOR_WIDTH{1'b0}}) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.div_valid_out) begin
          state_s = ST_RESP;
        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit_s = 1'b1;
          state_s       = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign req_ready_s = accept_s ? onehot(arb_idx_s) : {NUM_REQ{1'b0}};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, divider start strobe, result capture and timeout tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r   <= IDX_W'(NUM_REQ - 1);
      grant_r        <= {IDX_W{1'b0}};
      dividend_r     <= {DIVIDEND_WIDTH{1'b0}};
      divisor_r      <= {DIVISOR_WIDTH{1'b0}};
      quot_r         <= {DIVIDEND_WIDTH{1'b0}};
      rem_r          <= {DIVISOR_WIDTH{1'b0}};
      ovf_r          <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      timeout_err_r  <= 1'b0;
      div_valid_in_r <= 1'b0;
      resp_valid_r   <= {NUM_REQ{1'b0}};
    end else begin
      div_valid_in_r <= 1'b0;
      resp_valid_r   <= {NUM_REQ{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            grant_r        <= arb_idx_s;
            dividend_r     <= req_dividend_s[arb_idx_s];
            divisor_r      <= req_divisor_s[arb_idx_s];
            div_valid_in_r <= (req_divisor_s[arb_idx_s] != {DIVISOR_WIDTH{1'b0}});
          end
        end
        ST_ISSUE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (divisor_r == {DIVISOR_WIDTH{1'b0}}) begin
            quot_r       <= {DIVIDEND_WIDTH{1'b1}};
            rem_r        <= {DIVISOR_WIDTH{1'b0}};
            ovf_r        <= 1'b1;
            resp_valid_r <= onehot(grant_r);
          end
        end
        ST_WAIT: begin
          if (bus.div_valid_out) begin
            quot_r       <= bus.div_quotient;
            rem_r        <= bus.div_remainder;
            ovf_r        <= bus.div_overflow;
            resp_valid_r <= onehot(grant_r);
          end else if (timeout_hit_s) begin
            quot_r        <= {DIVIDEND_WIDTH{1'b0}};
            rem_r         <= {DIVISOR_WIDTH{1'b0}};
            ovf_r         <= 1'b1;
            timeout_err_r <= 1'b1;
            resp_valid_r  <= onehot(grant_r);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: last_grant_r <= grant_r;
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_s;
  assign bus.resp_valid     = resp_valid_r;
  assign bus.resp_quotient  = quot_r;
  assign bus.resp_remainder = rem_r;
  assign bus.resp_overflow  = ovf_r;
  assign bus.div_valid_in   = div_valid_in_r;
  assign bus.div_dividend   = dividend_r;
  assign bus.div_divisor    = divisor_r;
  assign bus.timeout_err    = timeout_err_r;

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_REQ, 4, number of requesters sharing the divider
  DIVIDEND_WIDTH, 64, dividend/quotient width
  DIVISOR_WIDTH, 32, divisor/remainder width
  TIMEOUT_CYCLES, 256, max WAIT cycles before abort
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock
  reset  in  1  reset, asynchronous, active-high
  req_valid  in  NUM_REQ  per-requester divide request
  req_ready  out  NUM_REQ  one-hot request accept
  req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  packed signed dividends, requester i at slice i
  req_divisor  in  NUM_REQ*DIVISOR_WIDTH  packed signed divisors
  resp_valid  out  NUM_REQ  one-hot result strobe
  resp_quotient  out  DIVIDEND_WIDTH  shared result quotient
  resp_remainder  out  DIVISOR_WIDTH  shared result remainder
  resp_overflow  out  1  divider overflow, divide-by-zero or timeout
  div_valid_in  out  1  start pulse to the shared divider
  div_dividend  out  DIVIDEND_WIDTH  registered dividend to the divider
  div_divisor  out  DIVISOR_WIDTH  registered divisor to the divider
  div_quotient  in  DIVIDEND_WIDTH  divider quotient
  div_remainder  in  DIVISOR_WIDTH  divider remainder
  div_overflow  in  1  divider overflow
  div_valid_out  in  1  divider done strobe
  timeout_err  out  1  sticky timeout flag

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with one operation outstanding at a time.
REQ-004 In IDLE with any req_valid, the block SHALL grant the first set bit searching upward from (last_grant+1) mod NUM_REQ, assert req_ready[grant] combinationally that cycle, latch the operands and grant index, and go to ISSUE.
REQ-005 req_ready SHALL be zero in every state except IDLE, and at most one bit SHALL be set.
REQ-006 ISSUE SHALL drive div_valid_in=1 for exactly one cycle with the latched operands, then go to WAIT.
REQ-007 If the latched divisor is 0, ISSUE SHALL skip the divider and go to RESP with quotient all-ones, remainder 0 and overflow=1.
REQ-008 WAIT SHALL latch div_quotient, div_remainder and div_overflow on div_valid_out, then go to RESP.
REQ-009 WAIT SHALL count cycles; when the count reaches TIMEOUT_CYCLES without div_valid_out, it SHALL go to RESP with quotient 0, remainder 0, overflow=1, and set timeout_err.
REQ-010 RESP SHALL assert resp_valid[grant] for one cycle with registered results held stable, update last_grant=grant, and return to IDLE.
REQ-011 Latency from accept to resp_valid SHALL be 3 + D cycles, where D is the cycles from div_valid_in to div_valid_out; the divide-by-zero path SHALL take 2 cycles.
REQ-012 A div_valid_out outside WAIT SHALL be ignored.
REQ-013 Changes on req_valid or req_* operands after acceptance SHALL NOT affect the in-flight operation.
REQ-014 Back-to-back throughput SHALL be one operation per 4 + D cycles; round-robin SHALL guarantee each continuously requesting port a grant within NUM_REQ operations.
REQ-015 Operands and results SHALL pass through unmodified; the arbiter performs no sign or width conversion.

Reset
REQ-016 On reset the block SHALL go to IDLE, set last_grant=NUM_REQ-1 (so requester 0 wins first), and zero all outputs, latched operands, results, the timeout counter and timeout_err.
REQ-017 A reset mid-operation SHALL abandon the operation with no resp_valid; the bench must also reset the shared divider.
REQ-018 timeout_err SHALL clear only on reset.

Structure
REQ-019 A shared package SHALL hold the state enum type and the default width constants (64/32).
REQ-020 One sub-module, rr_arbiter (parameterised NUM_REQ, combinational grant from request vector and last_grant), SHALL be used; the divider stays external.

Verification
REQ-021 Single request: req 0 with 1000<<10 / 3 -> req_ready[0] in the same cycle; resp_valid[0] after 3+D cycles with quotient 341333, remainder 1, overflow 0.
REQ-022 Simultaneous: all 4 requesters held valid from reset -> grant order 0,1,2,3,0; one resp_valid per operation, matching the granted index.
REQ-023 Divide-by-zero: divisor 0 on req 2 -> no div_valid_in; resp_valid[2] 2 cycles after accept; quotient all-ones, overflow 1.
REQ-024 Timeout: divider model never returns -> resp_valid after TIMEOUT_CYCLES in WAIT; overflow 1; timeout_err stays 1 until reset.
REQ-025 Reset in WAIT, then req 1 -> no stale resp_valid; the new op completes correctly; a spurious div_valid_out in IDLE is ignored.
REQ-026 Negative dividend -7 / 2 on req 3 -> the response equals the divider output bit-for-bit; req_ready stays low while busy.
